// File: rtl/mux_scan_controller.sv
// -----------------------------------------------------------------------------
// mux_scan_controller
//
// Sweeps the select lines of a downstream 4:1 mux across its four channels.
// Each channel is held for DWELL cycles. On the last cycle of each dwell the
// mux output is captured into one bit of cap. A completed sweep gives a
// one-cycle done pulse and sets cap_valid.
//
// Parameters
//   DWELL      select-hold cycles per channel, legal 1..15 (other values act as 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   sweep request, sampled in IDLE only
//   cont       in   continuous mode, sampled in DONE
//   mask [3:0] in   per-channel skip bits (only with MUX_SCAN_MASK_EN)
//   y          in   output of the downstream 4:1 mux
//   s1, s0     out  mux select MSB / LSB (always equal to the channel counter)
//   busy       out  high in SCAN and DONE
//   done       out  one-cycle pulse at sweep completion
//   cap [3:0]  out  captured mux output, bit n = channel n
//   cap_valid  out  cap holds a completed sweep
//
// Configuration
//   MUX_SCAN_MASK_EN  when defined, mask is latched at each sweep start and
//                     masked channels are skipped with zero cycles; their cap
//                     bit stays 0. If every channel is masked, SCAN is skipped
//                     and the FSM goes straight to DONE. When undefined, mask
//                     is ignored and all four channels are scanned.
// -----------------------------------------------------------------------------
module mux_scan_controller #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] mask,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       done,
  output logic [3:0] cap,
  output logic       cap_valid
);

  // Out-of-range dwell values collapse to a single cycle per channel.
  localparam logic [3:0] DWELL_EFF  = (DWELL >= 1 && DWELL <= 15) ? DWELL[3:0] : 4'd1;
  localparam logic [3:0] DWELL_LAST = DWELL_EFF - 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [3:0]  cap_q, cap_d;
  logic        cap_valid_q, cap_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Skip masks: start_skip_s applies to the channel chosen at a sweep start,
  // scan_skip_s to channel advances during a sweep.
  logic [3:0]  start_skip_s;
  logic [3:0]  scan_skip_s;
  logic [2:0]  first_s;
  logic [2:0]  next_s;

`ifdef MUX_SCAN_MASK_EN
  logic [3:0]  mask_q, mask_d;
  assign start_skip_s = mask;
  assign scan_skip_s  = mask_q;
`else
  logic        unused_mask_s;
  assign unused_mask_s = ^mask;
  assign start_skip_s  = 4'b0000;
  assign scan_skip_s   = 4'b0000;
`endif

  // Lowest non-skipped channel at index >= lo; result is {found, channel}.
  function automatic logic [2:0] find_chan(input logic [3:0] skip, input logic [2:0] lo);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(lo) && !skip[i]) begin
        r = {1'b1, i[1:0]};
      end
    end
    return r;
  endfunction

  assign first_s = find_chan(start_skip_s, 3'd0);
  assign next_s  = find_chan(scan_skip_s, {1'b0, ch_q} + 3'd1);

  // Next-state and datapath update for the sweep FSM.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dwell_d     = dwell_q;
    cap_d       = cap_q;
    cap_valid_d = cap_valid_q;
`ifdef MUX_SCAN_MASK_EN
    mask_d      = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef MUX_SCAN_MASK_EN
          mask_d = mask;
`endif
          cap_d   = 4'b0000;
          dwell_d = 4'd0;
          if (first_s[2]) begin
            state_d     = ST_SCAN;
            ch_d        = first_s[1:0];
            cap_valid_d = 1'b0;
          end else begin
            // Every channel masked: the sweep is complete immediately.
            state_d     = ST_DONE;
            cap_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          cap_d[ch_q] = y;
          dwell_d     = 4'd0;
          if (next_s[2]) begin
            ch_d = next_s[1:0];
          end else begin
            state_d     = ST_DONE;
            cap_valid_d = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (cont) begin
`ifdef MUX_SCAN_MASK_EN
          mask_d = mask;
`endif
          // Old results stay until overwritten, except channels that this
          // sweep will skip, which must read 0.
          cap_d   = cap_q & ~start_skip_s;
          dwell_d = 4'd0;
          if (first_s[2]) begin
            state_d     = ST_SCAN;
            ch_d        = first_s[1:0];
            cap_valid_d = 1'b0;
          end else begin
            state_d     = ST_DONE;
            cap_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= 2'd0;
      dwell_q     <= 4'd0;
      cap_q       <= 4'b0000;
      cap_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MUX_SCAN_MASK_EN
      mask_q      <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dwell_q     <= dwell_d;
      cap_q       <= cap_d;
      cap_valid_q <= cap_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MUX_SCAN_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign s1        = ch_q[1];
  assign s0        = ch_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign cap       = cap_q;
  assign cap_valid = cap_valid_q;

endmodule
